// File: rtl/wb_mem_2_ppfifo.sv
// Wishbone read master that drains two ping-pong memory regions, in strict
// alternation, into the write side of a ping-pong FIFO.
module wb_mem_2_ppfifo #(
    parameter int unsigned ADDR_INC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,

    input  logic [31:0] i_memory_0_base,
    input  logic [31:0] i_memory_0_size,
    input  logic        i_memory_0_ready,
    output logic [31:0] o_memory_0_count,
    output logic        o_memory_0_finished,
    output logic        o_memory_0_empty,

    input  logic [31:0] i_memory_1_base,
    input  logic [31:0] i_memory_1_size,
    input  logic        i_memory_1_ready,
    output logic [31:0] o_memory_1_count,
    output logic        o_memory_1_finished,
    output logic        o_memory_1_empty,

    output logic        o_read_finished,

    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int,

    input  logic [1:0]  i_ppfifo_rdy,
    output logic [1:0]  o_ppfifo_act,
    input  logic [23:0] i_ppfifo_size,
    output logic        o_ppfifo_stb,
    output logic [31:0] o_ppfifo_data
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQUEST  = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_POST     = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic [31:0] ADDR_INC_W = 32'(ADDR_INC);

    logic [2:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] base_q  [2];
    logic [31:0] base_d  [2];
    logic [31:0] size_q  [2];
    logic [31:0] size_d  [2];
    logic [31:0] count_q [2];
    logic [31:0] count_d [2];
    logic [1:0]  fin_q, fin_d;
    logic [1:0]  empty_q, empty_d;
    logic [31:0] fifo_count_q, fifo_count_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [31:0] adr_q, adr_d;
    logic [1:0]  act_q, act_d;
    logic        fifo_stb_q, fifo_stb_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        read_finished_q, read_finished_d;

    logic [31:0] ld_base  [2];
    logic [31:0] ld_size  [2];
    logic [1:0]  ld_ready;
    logic [1:0]  load_ok;
    logic        region_busy;
    logic        unused_ok;

    assign ld_base[0]  = i_memory_0_base;
    assign ld_base[1]  = i_memory_1_base;
    assign ld_size[0]  = i_memory_0_size;
    assign ld_size[1]  = i_memory_1_size;
    assign ld_ready    = {i_memory_1_ready, i_memory_0_ready};
    assign unused_ok   = i_mem_int;

    // The pointed-to region is busy while a word is in flight, and also while
    // it is parked part-way through (FIFO side full or enable dropped), so a
    // reload cannot corrupt a resumable transfer.
    assign region_busy = (state_q == ST_REQUEST) || (state_q == ST_WAIT_ACK) ||
                         (state_q == ST_POST) ||
                         (!empty_q[ptr_q] && (count_q[ptr_q] != 32'd0));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_load
            assign load_ok[gi] = ld_ready[gi] && (ld_size[gi] != 32'd0) &&
                                 !((ptr_q == 1'(gi)) && region_busy);
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        base_d          = base_q;
        size_d          = size_q;
        count_d         = count_q;
        fin_d           = fin_q;
        empty_d         = empty_q;
        fifo_count_d    = fifo_count_q;
        cyc_d           = cyc_q;
        stb_d           = stb_q;
        adr_d           = adr_q;
        act_d           = act_q;
        fifo_stb_d      = 1'b0;
        fifo_data_d     = fifo_data_q;
        read_finished_d = 1'b0;

        for (int r = 0; r < 2; r++) begin
            if (load_ok[r]) begin
                base_d[r]  = ld_base[r];
                size_d[r]  = ld_size[r];
                count_d[r] = 32'd0;
                fin_d[r]   = 1'b0;
                empty_d[r] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable && !empty_q[ptr_q] && (i_ppfifo_rdy != 2'b00)) begin
                    act_d        = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                    fifo_count_d = 32'd0;
                    state_d      = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                adr_d   = base_q[ptr_q] + (count_q[ptr_q] * ADDR_INC_W);
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_mem_ack) begin
                    fifo_data_d    = i_mem_dat;
                    cyc_d          = 1'b0;
                    stb_d          = 1'b0;
                    fifo_stb_d     = 1'b1;
                    count_d[ptr_q] = count_q[ptr_q] + 32'd1;
                    fifo_count_d   = fifo_count_q + 32'd1;
                    state_d        = ST_POST;
                end
            end
            ST_POST: begin
                // Region completion wins over a simultaneously full FIFO side,
                // so the side is released exactly once.
                if (count_q[ptr_q] == size_q[ptr_q]) begin
                    fin_d[ptr_q]    = 1'b1;
                    empty_d[ptr_q]  = 1'b1;
                    read_finished_d = 1'b1;
                    ptr_d           = ~ptr_q;
                    act_d           = 2'b00;
                    state_d         = ST_RELEASE;
                end else if (fifo_count_q == {8'd0, i_ppfifo_size}) begin
                    act_d   = 2'b00;
                    state_d = ST_RELEASE;
                end else if (!i_enable) begin
                    act_d   = 2'b00;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_REQUEST;
                end
            end
            ST_RELEASE: begin
                act_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                act_d   = 2'b00;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ptr_q           <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                base_q[r]  <= 32'd0;
                size_q[r]  <= 32'd0;
                count_q[r] <= 32'd0;
            end
            fin_q           <= 2'b00;
            empty_q         <= 2'b11;
            fifo_count_q    <= 32'd0;
            cyc_q           <= 1'b0;
            stb_q           <= 1'b0;
            adr_q           <= 32'd0;
            act_q           <= 2'b00;
            fifo_stb_q      <= 1'b0;
            fifo_data_q     <= 32'd0;
            read_finished_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            for (int r = 0; r < 2; r++) begin
                base_q[r]  <= base_d[r];
                size_q[r]  <= size_d[r];
                count_q[r] <= count_d[r];
            end
            fin_q           <= fin_d;
            empty_q         <= empty_d;
            fifo_count_q    <= fifo_count_d;
            cyc_q           <= cyc_d;
            stb_q           <= stb_d;
            adr_q           <= adr_d;
            act_q           <= act_d;
            fifo_stb_q      <= fifo_stb_d;
            fifo_data_q     <= fifo_data_d;
            read_finished_q <= read_finished_d;
        end
    end

    assign o_memory_0_count    = count_q[0];
    assign o_memory_1_count    = count_q[1];
    assign o_memory_0_finished = fin_q[0];
    assign o_memory_1_finished = fin_q[1];
    assign o_memory_0_empty    = empty_q[0];
    assign o_memory_1_empty    = empty_q[1];
    assign o_read_finished     = read_finished_q;

    assign o_mem_we            = 1'b0;
    assign o_mem_dat           = 32'd0;
    assign o_mem_cyc           = cyc_q;
    assign o_mem_stb           = stb_q;
    assign o_mem_sel           = cyc_q ? 4'hF : 4'h0;
    assign o_mem_adr           = adr_q;

    assign o_ppfifo_act        = act_q;
    assign o_ppfifo_stb        = fifo_stb_q;
    assign o_ppfifo_data       = fifo_data_q;

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Directed bench for wb_mem_2_ppfifo: a table of single-region transfers plus
// hand-written sequences for ordering, enable drop, ignored loads and reset.
module tb_wb_mem_2_ppfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [31:0] i_memory_0_base, i_memory_0_size;
    logic        i_memory_0_ready;
    logic [31:0] o_memory_0_count;
    logic        o_memory_0_finished, o_memory_0_empty;
    logic [31:0] i_memory_1_base, i_memory_1_size;
    logic        i_memory_1_ready;
    logic [31:0] o_memory_1_count;
    logic        o_memory_1_finished, o_memory_1_empty;
    logic        o_read_finished;
    logic        o_mem_we, o_mem_stb, o_mem_cyc;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_adr, o_mem_dat;
    logic [31:0] i_mem_dat = 32'd0;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_int;
    logic [1:0]  i_ppfifo_rdy;
    logic [1:0]  o_ppfifo_act;
    logic [23:0] i_ppfifo_size;
    logic        o_ppfifo_stb;
    logic [31:0] o_ppfifo_data;

    wb_mem_2_ppfifo #(.ADDR_INC(1)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
        .i_memory_0_ready(i_memory_0_ready), .o_memory_0_count(o_memory_0_count),
        .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
        .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
        .i_memory_1_ready(i_memory_1_ready), .o_memory_1_count(o_memory_1_count),
        .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
        .o_read_finished(o_read_finished),
        .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
        .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
        .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
        .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
        .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
        .o_ppfifo_data(o_ppfifo_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] size;
        logic [23:0] fsize;
        logic [1:0]  rdy;
        int          exp_blocks;
        logic [1:0]  exp_first;
        int          exp_last_len;
    } vec_t;

    vec_t        vecs [6];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [31:0] addr_q [$];
    logic [31:0] data_q [$];
    logic [1:0]  blk_side_q [$];
    int          blk_len_q [$];
    int          rf_cnt = 0;
    int          stb_cnt = 0;
    int          viol_cnt = 0;
    int          cur_len = 0;
    logic [1:0]  prev_act = 2'b00;
    logic [1:0]  rdy_reg = 2'b00;
    logic        rdy_req = 1'b0;
    logic [1:0]  rdy_val = 2'b00;
    logic        mem_ack_en = 1'b1;

    assign i_ppfifo_rdy = rdy_reg;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_0000;
    endfunction

    // Memory slave: one ack per strobe, one cycle after strobe is seen.
    always @(posedge clk) begin
        if (mem_ack_en && o_mem_cyc && o_mem_stb && !i_mem_ack) begin
            i_mem_ack <= 1'b1;
            i_mem_dat <= mem_model(o_mem_adr);
        end else begin
            i_mem_ack <= 1'b0;
        end
    end

    // Bus/FIFO monitor and FIFO-side availability model.
    always @(negedge clk) begin
        if (o_mem_cyc && i_mem_ack) addr_q.push_back(o_mem_adr);
        if (o_ppfifo_stb) begin
            data_q.push_back(o_ppfifo_data);
            stb_cnt <= stb_cnt + 1;
            if (o_ppfifo_act == 2'b00) viol_cnt <= viol_cnt + 1;
        end
        if (o_read_finished) rf_cnt <= rf_cnt + 1;
        if (prev_act == 2'b00 && o_ppfifo_act != 2'b00) begin
            blk_side_q.push_back(o_ppfifo_act);
            cur_len <= 0;
        end else begin
            if (prev_act != 2'b00 && o_ppfifo_act == 2'b00) blk_len_q.push_back(cur_len);
            cur_len <= cur_len + (o_ppfifo_stb ? 1 : 0);
        end
        if (rdy_req) rdy_reg <= rdy_val;
        else if (prev_act != 2'b00 && o_ppfifo_act == 2'b00)
            rdy_reg <= prev_act[0] ? 2'b10 : 2'b01;
        prev_act <= o_ppfifo_act;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_rdy(input logic [1:0] v);
        rdy_val = v;
        rdy_req = 1'b1;
        tick();
        rdy_req = 1'b0;
    endtask

    task automatic load_region(input int r, input logic [31:0] b, input logic [31:0] s);
        if (r == 0) begin
            i_memory_0_base = b; i_memory_0_size = s; i_memory_0_ready = 1'b1;
        end else begin
            i_memory_1_base = b; i_memory_1_size = s; i_memory_1_ready = 1'b1;
        end
        tick();
        i_memory_0_ready = 1'b0;
        i_memory_1_ready = 1'b0;
    endtask

    task automatic wait_rf(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rf_cnt >= target) break;
            tick();
        end
        chk("rf_wait_done", 32'(rf_cnt >= target), 32'd1);
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < data_q.size()) ? data_q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check_words(input string tag, input int start, input logic [31:0] base,
                               input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_addr"}, addr_at(start + k), base + 32'(k));
            chk({tag, "_data"}, data_at(start + k), mem_model(base + 32'(k)));
        end
    endtask

    function automatic logic [31:0] count_of(input int r);
        return (r == 0) ? o_memory_0_count : o_memory_1_count;
    endfunction
    function automatic logic fin_of(input int r);
        return (r == 0) ? o_memory_0_finished : o_memory_1_finished;
    endfunction
    function automatic logic empty_of(input int r);
        return (r == 0) ? o_memory_0_empty : o_memory_1_empty;
    endfunction

    int sa, sd, srf, sblk, sstb;

    initial begin
        vecs[0] = '{32'h0000_0100, 32'd4,  24'd16, 2'b01, 1, 2'b01, 4};
        vecs[1] = '{32'h0000_0200, 32'd2,  24'd16, 2'b11, 1, 2'b01, 2};
        vecs[2] = '{32'h0000_1000, 32'd20, 24'd8,  2'b11, 3, 2'b01, 4};
        vecs[3] = '{32'hFFFF_FFFE, 32'd3,  24'd16, 2'b10, 1, 2'b10, 3};
        vecs[4] = '{32'h0000_0300, 32'd5,  24'd5,  2'b01, 1, 2'b01, 5};
        vecs[5] = '{32'h0000_0400, 32'd1,  24'd1,  2'b10, 1, 2'b10, 1};

        rst = 1'b1; i_enable = 1'b0; i_mem_int = 1'b0;
        i_memory_0_base = 32'd0; i_memory_0_size = 32'd0; i_memory_0_ready = 1'b0;
        i_memory_1_base = 32'd0; i_memory_1_size = 32'd0; i_memory_1_ready = 1'b0;
        i_ppfifo_size = 24'd16;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_cyc", 32'(o_mem_cyc), 32'd0);
        chk("rst_stb", 32'(o_mem_stb), 32'd0);
        chk("rst_sel", 32'(o_mem_sel), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        chk("rst_adr", o_mem_adr, 32'd0);
        chk("rst_act", 32'(o_ppfifo_act), 32'd0);
        chk("rst_fstb", 32'(o_ppfifo_stb), 32'd0);
        chk("rst_count0", o_memory_0_count, 32'd0);
        chk("rst_count1", o_memory_1_count, 32'd0);
        chk("rst_fin", 32'({o_memory_1_finished, o_memory_0_finished}), 32'd0);
        chk("rst_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);
        chk("rst_rdfin", 32'(o_read_finished), 32'd0);

        i_enable = 1'b1;
        for (int v = 0; v < 6; v++) begin
            int r;
            r = v % 2;
            set_rdy(vecs[v].rdy);
            i_ppfifo_size = vecs[v].fsize;
            sa = addr_q.size(); sd = data_q.size(); srf = rf_cnt;
            sblk = blk_side_q.size(); sstb = stb_cnt;
            load_region(r, vecs[v].base, vecs[v].size);
            wait_rf(srf + 1, 2000);
            repeat (4) tick();
            chk("v_nwords", 32'(addr_q.size() - sa), vecs[v].size);
            check_words("v", sa, vecs[v].base, int'(vecs[v].size));
            chk("v_nstb", 32'(stb_cnt - sstb), vecs[v].size);
            chk("v_count", count_of(r), vecs[v].size);
            chk("v_fin", 32'(fin_of(r)), 32'd1);
            chk("v_empty", 32'(empty_of(r)), 32'd1);
            chk("v_rdfin", 32'(rf_cnt - srf), 32'd1);
            chk("v_blocks", 32'(blk_side_q.size() - sblk), 32'(vecs[v].exp_blocks));
            chk("v_first_act", 32'((sblk < blk_side_q.size()) ? blk_side_q[sblk] : 2'b00),
                32'(vecs[v].exp_first));
            chk("v_last_len", 32'((blk_len_q.size() > 0) ? blk_len_q[blk_len_q.size()-1] : -1),
                32'(vecs[v].exp_last_len));
            chk("v_act_idle", 32'(o_ppfifo_act), 32'd0);
            $display("vector %0d: region %0d base %h size %0d fifo %0d done", v, r,
                     vecs[v].base, vecs[v].size, vecs[v].fsize);
        end

        // Ping-pong order: region 1 loaded first must wait behind region 0.
        set_rdy(2'b01);
        i_ppfifo_size = 24'd16;
        sa = addr_q.size(); srf = rf_cnt;
        load_region(1, 32'h200, 32'd2);
        repeat (10) tick();
        chk("pp_wait_words", 32'(addr_q.size() - sa), 32'd0);
        chk("pp_wait_cyc", 32'(o_mem_cyc), 32'd0);
        load_region(0, 32'h500, 32'd3);
        wait_rf(srf + 2, 2000);
        repeat (4) tick();
        check_words("pp_r0", sa, 32'h500, 3);
        check_words("pp_r1", sa + 3, 32'h200, 2);
        chk("pp_rdfin", 32'(rf_cnt - srf), 32'd2);
        chk("pp_fin", 32'({o_memory_1_finished, o_memory_0_finished}), 32'd3);
        $display("sequence ping-pong: 5 words across both regions");

        // Enable dropped after word 2 of 6; transfer resumes at base+2.
        set_rdy(2'b01);
        sa = addr_q.size(); srf = rf_cnt;
        load_region(0, 32'h600, 32'd6);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() >= sa + 2) break;
        end
        i_enable = 1'b0;
        repeat (8) tick();
        chk("en_words", 32'(addr_q.size() - sa), 32'd2);
        chk("en_count", o_memory_0_count, 32'd2);
        chk("en_act", 32'(o_ppfifo_act), 32'd0);
        chk("en_cyc", 32'(o_mem_cyc), 32'd0);
        chk("en_fin", 32'(o_memory_0_finished), 32'd0);
        i_enable = 1'b1;
        wait_rf(srf + 1, 2000);
        repeat (4) tick();
        check_words("en", sa, 32'h600, 6);
        chk("en_count_end", o_memory_0_count, 32'd6);
        $display("sequence enable drop: resumed and finished 6 words");

        // Reload of the active region and a zero-size load are both ignored.
        set_rdy(2'b01);
        sa = addr_q.size(); srf = rf_cnt;
        load_region(1, 32'h700, 32'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() >= sa + 1) break;
        end
        i_memory_1_base = 32'h900; i_memory_1_size = 32'd9; i_memory_1_ready = 1'b1;
        i_memory_0_base = 32'hBAD; i_memory_0_size = 32'd0; i_memory_0_ready = 1'b1;
        tick();
        i_memory_0_ready = 1'b0; i_memory_1_ready = 1'b0;
        wait_rf(srf + 1, 2000);
        repeat (4) tick();
        chk("ign_words", 32'(addr_q.size() - sa), 32'd4);
        check_words("ign", sa, 32'h700, 4);
        chk("ign_count1", o_memory_1_count, 32'd4);
        chk("ign_count0", o_memory_0_count, 32'd6);
        chk("ign_empty0", 32'(o_memory_0_empty), 32'd1);
        chk("ign_fin0", 32'(o_memory_0_finished), 32'd1);
        $display("sequence ignored loads: region 1 read 4 words unchanged");

        // Reset while waiting for an ack.
        mem_ack_en = 1'b0;
        set_rdy(2'b01);
        load_region(0, 32'hA00, 32'd4);
        for (int i = 0; i < 20; i++) begin
            if (o_mem_cyc) break;
            tick();
        end
        chk("rst_mid_cyc_seen", 32'(o_mem_cyc), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_cyc", 32'(o_mem_cyc), 32'd0);
        chk("rst_mid_stb", 32'(o_mem_stb), 32'd0);
        chk("rst_mid_act", 32'(o_ppfifo_act), 32'd0);
        chk("rst_mid_counts", o_memory_0_count | o_memory_1_count, 32'd0);
        chk("rst_mid_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);
        chk("rst_mid_fin", 32'({o_memory_1_finished, o_memory_0_finished}), 32'd0);
        rst = 1'b0;
        mem_ack_en = 1'b1;
        sa = addr_q.size(); sstb = stb_cnt;
        repeat (30) tick();
        chk("rst_quiet_stb", 32'(stb_cnt - sstb), 32'd0);
        chk("rst_quiet_words", 32'(addr_q.size() - sa), 32'd0);
        chk("rst_quiet_cyc", 32'(o_mem_cyc), 32'd0);
        $display("sequence reset in WAIT_ACK: bus and FIFO quiet afterwards");

        chk("stb_without_act", 32'(viol_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
